// File: rtl/render_scheduler.sv
// Frame-level sequencer: per-frame car displacement update, renderer start,
// and vsync-aligned front/back buffer swap with drop and timeout accounting.
module render_scheduler #(
  parameter int W              = 320,
  parameter int H              = 240,
  parameter int WB             = 88,
  parameter int HB             = 44,
  parameter int STEP           = 2,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               vsync_tick,
  input  logic               btn_l,
  input  logic               btn_r,
  input  logic               btn_u,
  input  logic               btn_d,
  input  logic               r_busy,
  input  logic               r_done,
  output logic               r_start,
  output logic signed [11:0] dx,
  output logic signed [11:0] dy,
  output logic               wr_buf,
  output logic               rd_buf,
  output logic               swap_pulse,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        drop_cnt,
  output logic               timeout_err
);
  // state     | meaning
  // IDLE      | waiting for vsync_tick with en=1
  // UPDATE    | one cycle: sample buttons, move and clamp dx/dy
  // START     | issue one r_start once the renderer is not busy
  // WAIT_DONE | renderer running; timeout counter active
  // READY     | frame finished; waiting for vsync_tick to swap

  localparam logic signed [12:0] XLIM   = 13'((W - WB) / 2);
  localparam logic signed [12:0] YLIM   = 13'((H - HB) / 2);
  localparam logic signed [12:0] STEP13 = 13'(STEP);
  localparam int                 TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]      TLAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, UPDATE, START, WAIT_DONE, READY} state_t;

  state_t             state;
  logic [TW-1:0]      tcnt;
  logic signed [12:0] dx_move, dy_move, dx_sum, dy_sum;
  logic               do_swap, do_drop;

  function automatic logic signed [11:0] clamp(input logic signed [12:0] v,
                                               input logic signed [12:0] lim);
    logic signed [12:0] r;
    if (v > lim)       r = lim;
    else if (v < -lim) r = -lim;
    else               r = v;
    return $signed(r[11:0]);
  endfunction

  // Opposing buttons cancel; sums are formed one bit wider so clamping sees true overflow.
  always_comb begin
    dx_move = '0;
    dy_move = '0;
    if (btn_r && !btn_l) dx_move = STEP13;
    else if (btn_l && !btn_r) dx_move = -STEP13;
    if (btn_d && !btn_u) dy_move = STEP13;
    else if (btn_u && !btn_d) dy_move = -STEP13;
    dx_sum = $signed({dx[11], dx}) + dx_move;
    dy_sum = $signed({dy[11], dy}) + dy_move;
  end

  // A done pulse coinciding with vsync swaps at once rather than counting as a drop.
  always_comb begin
    do_swap = vsync_tick && ((state == READY) || (state == WAIT_DONE && r_done));
    do_drop = vsync_tick && ((state == UPDATE) || (state == START) ||
                             (state == WAIT_DONE && !r_done));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tcnt        <= '0;
      dx          <= '0;
      dy          <= '0;
      r_start     <= 1'b0;
      wr_buf      <= 1'b1;
      rd_buf      <= 1'b0;
      swap_pulse  <= 1'b0;
      frame_cnt   <= '0;
      drop_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      r_start    <= 1'b0;
      swap_pulse <= 1'b0;
      if (do_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (do_swap) begin
        wr_buf     <= ~wr_buf;
        rd_buf     <= ~rd_buf;
        swap_pulse <= 1'b1;
        frame_cnt  <= frame_cnt + 16'd1;
      end
      case (state)
        IDLE: if (en && vsync_tick) state <= UPDATE;
        UPDATE: begin
          dx      <= clamp(dx_sum, XLIM);
          dy      <= clamp(dy_sum, YLIM);
          r_start <= !r_busy;
          state   <= START;
        end
        START: begin
          if (r_start) begin
            state <= WAIT_DONE;
            tcnt  <= '0;
          end else begin
            r_start <= !r_busy;
          end
        end
        WAIT_DONE: begin
          if (r_done) begin
            if (vsync_tick) state <= en ? UPDATE : IDLE;
            else            state <= READY;
          end else if (tcnt == TLAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        READY: if (vsync_tick) state <= en ? UPDATE : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_render_scheduler.sv
// Randomized frame-level bench for render_scheduler with a behavioural model of
// displacement, buffer selection and frame/drop accounting.
module tb_render_scheduler;
  localparam int TO   = 70000;
  localparam int XLIM = 116;
  localparam int YLIM = 98;
  localparam int STEP = 2;

  logic clk = 1'b0;
  logic rst, en, vsync_tick, btn_l, btn_r, btn_u, btn_d, r_busy, r_done;
  logic r_start, wr_buf, rd_buf, swap_pulse, timeout_err;
  logic signed [11:0] dx, dy;
  logic [15:0] frame_cnt, drop_cnt;

  int checks = 0;
  int errors = 0;
  int m_dx, m_dy, m_frames, m_drops;
  logic m_wr;

  always #5 clk = ~clk;

  render_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .en(en), .vsync_tick(vsync_tick),
    .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
    .r_busy(r_busy), .r_done(r_done), .r_start(r_start),
    .dx(dx), .dy(dy), .wr_buf(wr_buf), .rd_buf(rd_buf),
    .swap_pulse(swap_pulse), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
    .timeout_err(timeout_err)
  );

  function automatic int clampi(input int v, input int lim);
    return (v > lim) ? lim : ((v < -lim) ? -lim : v);
  endfunction

  function automatic void m_reset();
    m_dx = 0; m_dy = 0; m_frames = 0; m_drops = 0; m_wr = 1'b1;
  endfunction

  function automatic void m_drop();
    if (m_drops < 65535) m_drops++;
  endfunction

  // Starts a frame from IDLE; returns at the negedge where the DUT sits in UPDATE.
  task automatic kick();
    @(negedge clk); vsync_tick = 1'b1;
    @(negedge clk); vsync_tick = 1'b0;
  endtask

  // Entry: at a negedge with the DUT in UPDATE. Exit: negedge right after the swap edge.
  task automatic run_frame(input logic bl, br, bu, bd,
                           input int busy, d, ndrop, vgap, en_off);
    int vfinal, sp, extra;
    logic drop_now;
    vfinal = d + vgap;
    sp     = d / (ndrop + 1);
    extra  = 0;
    btn_l = bl; btn_r = br; btn_u = bu; btn_d = bd;
    r_busy = (busy > 0);
    m_dx = clampi(m_dx + STEP * (int'(br) - int'(bl)), XLIM);
    m_dy = clampi(m_dy + STEP * (int'(bd) - int'(bu)), YLIM);
    for (int b = 1; b <= busy; b++) begin
      @(negedge clk);
      checks++;
      if (r_start !== 1'b0) begin
        errors++; $display("FAIL busy_hold b=%0d r_start=%b expected 0", b, r_start);
      end
      vsync_tick = (b == 1);
      if (b == 1) m_drop();
      if (b == busy) r_busy = 1'b0;
    end
    @(negedge clk);
    vsync_tick = 1'b0;
    checks++;
    if (r_start !== 1'b1) begin
      errors++; $display("FAIL start_pulse r_start=%b expected 1", r_start);
    end
    checks++;
    if (dx !== 12'(m_dx)) begin
      errors++; $display("FAIL dx got %0d expected %0d", dx, m_dx);
    end
    checks++;
    if (dy !== 12'(m_dy)) begin
      errors++; $display("FAIL dy got %0d expected %0d", dy, m_dy);
    end
    for (int t = 1; t <= vfinal + 1; t++) begin
      @(negedge clk);
      if (r_start === 1'b1) extra++;
      if (t == vfinal) begin
        checks++;
        if (swap_pulse !== 1'b0) begin
          errors++; $display("FAIL early_swap swap_pulse=%b expected 0", swap_pulse);
        end
      end
      if (t == vfinal + 1) begin
        m_wr = ~m_wr;
        m_frames = (m_frames + 1) % 65536;
        r_done = 1'b0; vsync_tick = 1'b0;
        checks++;
        if (swap_pulse !== 1'b1) begin
          errors++; $display("FAIL swap_pulse got %b expected 1", swap_pulse);
        end
        checks++;
        if (wr_buf !== m_wr || rd_buf !== ~m_wr) begin
          errors++; $display("FAIL bufs wr=%b rd=%b expected wr=%b rd=%b", wr_buf, rd_buf, m_wr, ~m_wr);
        end
        checks++;
        if (frame_cnt !== 16'(m_frames)) begin
          errors++; $display("FAIL frame_cnt got %0d expected %0d", frame_cnt, m_frames);
        end
        checks++;
        if (drop_cnt !== 16'(m_drops)) begin
          errors++; $display("FAIL drop_cnt got %0d expected %0d", drop_cnt, m_drops);
        end
      end else begin
        drop_now = (ndrop > 0) && (t < d) && (t % sp == 0) && (t / sp <= ndrop);
        r_done = (t == d);
        vsync_tick = (t == vfinal) || drop_now;
        if (drop_now) m_drop();
        if (t == en_off) en = 1'b0;
      end
    end
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL single_start extra r_start cycles=%0d expected 0", extra);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; vsync_tick = 1'b0; r_busy = 1'b0; r_done = 1'b0;
    btn_l = 1'b0; btn_r = 1'b0; btn_u = 1'b0; btn_d = 1'b0;
    m_reset();
    @(negedge clk); @(negedge clk);
    checks++;
    if (r_start !== 1'b0 || swap_pulse !== 1'b0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL reset_pulses r_start=%b swap=%b tmo=%b expected 0", r_start, swap_pulse, timeout_err);
    end
    checks++;
    if (dx !== 12'sd0 || dy !== 12'sd0) begin
      errors++; $display("FAIL reset_disp dx=%0d dy=%0d expected 0", dx, dy);
    end
    checks++;
    if (wr_buf !== 1'b1 || rd_buf !== 1'b0) begin
      errors++; $display("FAIL reset_bufs wr=%b rd=%b expected wr=1 rd=0", wr_buf, rd_buf);
    end
    checks++;
    if (frame_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnts frame=%0d drop=%0d expected 0", frame_cnt, drop_cnt);
    end
    rst = 1'b0;
    en  = 1'b1;
  endtask

  task automatic test_spurious_done();
    @(negedge clk); r_done = 1'b1;
    @(negedge clk); r_done = 1'b0;
    @(negedge clk);
    checks++;
    if (swap_pulse !== 1'b0 || r_start !== 1'b0 || frame_cnt !== 16'd0) begin
      errors++; $display("FAIL spurious_done swap=%b r_start=%b frame=%0d expected 0", swap_pulse, r_start, frame_cnt);
    end
  endtask

  task automatic test_basic();
    kick();
    run_frame(0, 0, 0, 0, 0, 1000, 0, 10, -1);
  endtask

  task automatic test_motion();
    for (int f = 0; f < 70; f++)
      run_frame(0, 1, 0, 0, 0, $urandom_range(5, 1), 0, $urandom_range(3, 0), -1);
    for (int f = 0; f < 3; f++)
      run_frame(1, 1, 0, 0, 0, $urandom_range(5, 1), 0, $urandom_range(3, 0), -1);
    for (int f = 0; f < 52; f++)
      run_frame(0, 0, 0, 1, 0, $urandom_range(5, 1), 0, $urandom_range(3, 0), -1);
    for (int f = 0; f < 3; f++)
      run_frame(0, 0, 1, 1, 0, $urandom_range(5, 1), 0, $urandom_range(3, 0), -1);
    for (int f = 0; f < 70; f++)
      run_frame(1, 0, 1, 0, 0, $urandom_range(5, 1), 0, $urandom_range(3, 0), -1);
  endtask

  task automatic test_drop();
    run_frame(0, 0, 0, 0, 0, 50, 2, 10, -1);
  endtask

  task automatic test_same_cycle();
    for (int f = 0; f < 4; f++)
      run_frame(0, 0, 0, 0, 0, $urandom_range(20, 1), 0, 0, -1);
  endtask

  task automatic test_busy();
    run_frame(0, 1, 0, 0, 3, 12, 0, 2, -1);
    run_frame(0, 0, 1, 0, 1, 7, 0, 0, -1);
  endtask

  task automatic test_random();
    int d, nd;
    for (int f = 0; f < 40; f++) begin
      d  = $urandom_range(30, 1);
      nd = $urandom_range(2, 0);
      if (d <= nd) nd = 0;
      run_frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(2, 0), d, nd, $urandom_range(4, 0), -1);
    end
  endtask

  task automatic test_disable();
    int act;
    run_frame(0, 0, 0, 0, 0, 15, 1, 3, 2);
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (r_start === 1'b1 || swap_pulse === 1'b1) act++;
    end
    checks++;
    if (act != 0) begin
      errors++; $display("FAIL disable_idle activity cycles=%0d expected 0", act);
    end
    en = 1'b1;
  endtask

  task automatic test_timeout_saturate();
    int act;
    kick();
    btn_l = 1'b0; btn_r = 1'b0; btn_u = 1'b0; btn_d = 1'b0;
    @(negedge clk);
    checks++;
    if (r_start !== 1'b1) begin
      errors++; $display("FAIL tmo_start r_start=%b expected 1", r_start);
    end
    for (int t = 1; t <= TO + 1; t++) begin
      @(negedge clk);
      if (t == 1001) begin
        checks++;
        if (drop_cnt !== 16'(m_drops)) begin
          errors++; $display("FAIL drop_run got %0d expected %0d", drop_cnt, m_drops);
        end
      end
      if (t == TO) begin
        checks++;
        if (timeout_err !== 1'b0) begin
          errors++; $display("FAIL tmo_early timeout_err=%b expected 0", timeout_err);
        end
      end
      if (t == TO + 1) begin
        vsync_tick = 1'b0;
        checks++;
        if (timeout_err !== 1'b1) begin
          errors++; $display("FAIL tmo_set timeout_err=%b expected 1", timeout_err);
        end
        checks++;
        if (drop_cnt !== 16'(m_drops)) begin
          errors++; $display("FAIL drop_sat got %0d expected %0d", drop_cnt, m_drops);
        end
        checks++;
        if (wr_buf !== m_wr || rd_buf !== ~m_wr || swap_pulse !== 1'b0 || frame_cnt !== 16'(m_frames)) begin
          errors++; $display("FAIL tmo_noswap wr=%b swap=%b frame=%0d expected wr=%b swap=0 frame=%0d",
                             wr_buf, swap_pulse, frame_cnt, m_wr, m_frames);
        end
      end else begin
        vsync_tick = 1'b1;
        m_drop();
      end
    end
    act = 0;
    repeat (10) begin
      @(negedge clk);
      if (r_start === 1'b1 || swap_pulse === 1'b1) act++;
    end
    checks++;
    if (act != 0) begin
      errors++; $display("FAIL tmo_idle activity cycles=%0d expected 0", act);
    end
    kick();
    run_frame(0, 0, 0, 0, 0, 8, 1, 2, -1);
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++; $display("FAIL tmo_sticky timeout_err=%b expected 1", timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    int act;
    btn_l = 1'b0; btn_r = 1'b1; btn_u = 1'b0; btn_d = 1'b1;
    @(negedge clk);
    checks++;
    if (r_start !== 1'b1) begin
      errors++; $display("FAIL rstmid_start r_start=%b expected 1", r_start);
    end
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({r_start, dx, dy, wr_buf, rd_buf, swap_pulse, frame_cnt, drop_cnt, timeout_err} !==
        {1'b0, 12'd0, 12'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid outs r_start=%b dx=%0d dy=%0d wr=%b rd=%b swap=%b frame=%0d drop=%0d tmo=%b expected all reset values",
               r_start, dx, dy, wr_buf, rd_buf, swap_pulse, frame_cnt, drop_cnt, timeout_err);
    end
    @(negedge clk);
    rst = 1'b0;
    btn_r = 1'b0; btn_d = 1'b0;
    m_reset();
    act = 0;
    repeat (5) begin
      @(negedge clk);
      if (r_start === 1'b1) act++;
    end
    checks++;
    if (act != 0) begin
      errors++; $display("FAIL rst_no_start r_start cycles=%0d expected 0", act);
    end
    kick();
    run_frame(0, 1, 0, 0, 0, 6, 0, 1, -1);
  endtask

  initial begin
    test_reset();
    test_spurious_done();
    test_basic();
    test_motion();
    test_drop();
    test_same_cycle();
    test_busy();
    test_random();
    test_disable();
    test_timeout_saturate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
